mc_cu: RTL and testbench

MC_CU -- requirements
Module: mc_cu

---
 rtl/mc_cu.sv | 184 ++++++++++++++++++
 tb/tb_mc_cu.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_cu.sv
// mc_cu: multi-cycle MIPS-subset control unit.
// Walks each instruction through IF -> ID -> (EXE -> (MEM) -> WB) and
// drives the datapath strobes for the current state.
// Ports:
//   clock, reset          - rising-edge clock, asynchronous active-high reset
//   op, func              - opcode/function fields of the instruction register
//   z                     - ALU zero flag (used in EXE for beq/bne)
//   imem_ready/dmem_ready - memory handshakes (IF / MEM wait states)
//   imem_req, dmem_req, dmem_we, wir, wpc, pcsource - fetch/memory/PC controls
//   wreg, m2reg, regrt, jal, shift, aluimm, sext, aluc - datapath controls
//   illegal               - one-cycle pulse in ID for an undecodable instruction
//   state                 - current state code (IDLE=0 .. WB=5)
module mc_cu (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       z,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       wir,
  output logic       wpc,
  output logic [1:0] pcsource,
  output logic       wreg,
  output logic       m2reg,
  output logic       regrt,
  output logic       jal,
  output logic       shift,
  output logic       aluimm,
  output logic       sext,
  output logic [3:0] aluc,
  output logic       illegal,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EXE  = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5
  } state_t;

  state_t cur, nxt;

  // Instruction decode
  logic r_type;
  logic i_add, i_sub, i_and, i_or, i_xor, i_gt, i_sll, i_srl, i_sra, i_jr;
  logic i_addi, i_andi, i_ori, i_xori, i_lw, i_sw, i_beq, i_bne, i_lui, i_j, i_jal;
  logic legal;

  always_comb begin
    r_type = (op == 6'b000000);
    i_add  = r_type & (func == 6'b100000);
    i_sub  = r_type & (func == 6'b100010);
    i_and  = r_type & (func == 6'b100100);
    i_or   = r_type & (func == 6'b100101);
    i_xor  = r_type & (func == 6'b100110);
    i_gt   = r_type & (func == 6'b100111);
    i_sll  = r_type & (func == 6'b000000);
    i_srl  = r_type & (func == 6'b000010);
    i_sra  = r_type & (func == 6'b000011);
    i_jr   = r_type & (func == 6'b001000);
    i_addi = (op == 6'b001000);
    i_andi = (op == 6'b001100);
    i_ori  = (op == 6'b001101);
    i_xori = (op == 6'b001110);
    i_lw   = (op == 6'b100011);
    i_sw   = (op == 6'b101011);
    i_beq  = (op == 6'b000100);
    i_bne  = (op == 6'b000101);
    i_lui  = (op == 6'b001111);
    i_j    = (op == 6'b000010);
    i_jal  = (op == 6'b000011);
    legal  = i_add | i_sub | i_and | i_or | i_xor | i_gt | i_sll | i_srl | i_sra |
             i_jr | i_addi | i_andi | i_ori | i_xori | i_lw | i_sw | i_beq |
             i_bne | i_lui | i_j | i_jal;
  end

  // ALU operation code
  always_comb begin
    aluc = 4'b0000;
    if (i_sub | i_beq | i_bne)  aluc = 4'b0100;
    else if (i_and | i_andi)    aluc = 4'b0001;
    else if (i_or | i_ori)      aluc = 4'b0101;
    else if (i_xor | i_xori)    aluc = 4'b0010;
    else if (i_sll)             aluc = 4'b0011;
    else if (i_srl)             aluc = 4'b0111;
    else if (i_sra)             aluc = 4'b1111;
    else if (i_gt)              aluc = 4'b1100;
    else if (i_lui)             aluc = 4'b0110;
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cur <= S_IDLE;
    else       cur <= nxt;
  end

  // Next state and strobes
  always_comb begin
    nxt      = cur;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    wir      = 1'b0;
    wpc      = 1'b0;
    pcsource = 2'b00;
    wreg     = 1'b0;
    illegal  = 1'b0;
    shift    = 1'b0;
    aluimm   = 1'b0;
    sext     = 1'b0;
    regrt    = 1'b0;
    m2reg    = 1'b0;
    jal      = 1'b0;

    if (cur != S_IDLE) begin
      shift  = i_sll | i_srl | i_sra;
      aluimm = i_addi | i_andi | i_ori | i_xori | i_lw | i_sw | i_lui;
      sext   = i_addi | i_lw | i_sw | i_beq | i_bne;
      regrt  = i_addi | i_andi | i_ori | i_xori | i_lw | i_lui;
      m2reg  = i_lw;
      jal    = i_jal;
    end

    unique case (cur)
      S_IDLE: nxt = S_IF;
      S_IF: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          wir = 1'b1;
          wpc = 1'b1;
          nxt = S_ID;
        end
      end
      S_ID: begin
        nxt = S_IF;
        if (!legal) begin
          illegal = 1'b1;
        end else if (i_j | i_jal) begin
          wpc      = 1'b1;
          pcsource = 2'b11;
          wreg     = i_jal;
        end else if (i_jr) begin
          wpc      = 1'b1;
          pcsource = 2'b10;
        end else begin
          nxt = S_EXE;
        end
      end
      S_EXE: begin
        if (i_beq | i_bne) begin
          nxt = S_IF;
          if ((i_beq & z) | (i_bne & ~z)) begin
            wpc      = 1'b1;
            pcsource = 2'b01;
          end
        end else if (i_lw | i_sw) begin
          nxt = S_MEM;
        end else begin
          nxt = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = i_sw;
        if (dmem_ready) nxt = i_sw ? S_IF : S_WB;
      end
      S_WB: begin
        wreg = 1'b1;
        nxt  = S_IF;
      end
      default: nxt = S_IDLE;
    endcase
  end

  assign state = cur;

endmodule

// File: tb/tb_mc_cu.sv
// tb_mc_cu: directed self-checking bench for mc_cu.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mc_cu;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] op, func;
  logic       z, imem_ready, dmem_ready;
  logic       imem_req, dmem_req, dmem_we, wir, wpc;
  logic [1:0] pcsource;
  logic       wreg, m2reg, regrt, jal, shift, aluimm, sext, illegal;
  logic [3:0] aluc;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mc_cu dut (
    .clock(clock), .reset(reset), .op(op), .func(func), .z(z),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .wir(wir), .wpc(wpc), .pcsource(pcsource), .wreg(wreg),
    .m2reg(m2reg), .regrt(regrt), .jal(jal), .shift(shift),
    .aluimm(aluimm), .sext(sext), .aluc(aluc), .illegal(illegal),
    .state(state)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic set_instr(input logic [5:0] o, input logic [5:0] f);
    op   = o;
    func = f;
  endtask

  initial begin
    reset = 1'b1; op = '0; func = '0; z = 1'b0;
    imem_ready = 1'b1; dmem_ready = 1'b1;
    step();
    chk("rst_state", 8'(state), 8'd0);
    chk("rst_imem_req", 8'(imem_req), 8'd0);
    chk("rst_wreg", 8'(wreg), 8'd0);

    // release reset between edges; first edge goes to IF
    reset = 1'b0;
    #1 chk("rel_state_idle", 8'(state), 8'd0);
    chk("rel_imem_req", 8'(imem_req), 8'd0);
    step();
    chk("if_state", 8'(state), 8'd1);
    chk("if_imem_req", 8'(imem_req), 8'd1);

    // add: 1,2,3,5,1
    set_instr(6'b000000, 6'b100000);
    chk("add_if_wir", 8'(wir), 8'd1);
    chk("add_if_wpc", 8'(wpc), 8'd1);
    chk("add_if_pcsrc", 8'(pcsource), 8'd0);
    step();
    chk("add_id_state", 8'(state), 8'd2);
    chk("add_id_wreg", 8'(wreg), 8'd0);
    step();
    chk("add_exe_state", 8'(state), 8'd3);
    chk("add_exe_aluc", 8'(aluc), 8'h0);
    chk("add_exe_regrt", 8'(regrt), 8'd0);
    chk("add_exe_wreg", 8'(wreg), 8'd0);
    step();
    chk("add_wb_state", 8'(state), 8'd5);
    chk("add_wb_wreg", 8'(wreg), 8'd1);
    step();
    chk("add_ret_state", 8'(state), 8'd1);
    chk("add_ret_wreg", 8'(wreg), 8'd0);

    // IF wait on imem_ready
    imem_ready = 1'b0;
    #1 chk("ifw_wir", 8'(wir), 8'd0);
    chk("ifw_wpc", 8'(wpc), 8'd0);
    chk("ifw_imem_req", 8'(imem_req), 8'd1);
    step();
    chk("ifw_state", 8'(state), 8'd1);

    // lw with dmem_ready low for 3 MEM cycles
    imem_ready = 1'b1;
    set_instr(6'b100011, 6'b000000);
    #1 chk("lw_if_wir", 8'(wir), 8'd1);
    step();
    chk("lw_id_state", 8'(state), 8'd2);
    step();
    chk("lw_exe_state", 8'(state), 8'd3);
    chk("lw_exe_aluimm", 8'(aluimm), 8'd1);
    chk("lw_exe_sext", 8'(sext), 8'd1);
    dmem_ready = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("lw_memw_state", 8'(state), 8'd4);
      chk("lw_memw_req", 8'(dmem_req), 8'd1);
      chk("lw_memw_we", 8'(dmem_we), 8'd0);
      chk("lw_memw_wreg", 8'(wreg), 8'd0);
      step();
    end
    chk("lw_mem4_state", 8'(state), 8'd4);
    dmem_ready = 1'b1;
    #1 chk("lw_mem4_req", 8'(dmem_req), 8'd1);
    step();
    chk("lw_wb_state", 8'(state), 8'd5);
    chk("lw_wb_m2reg", 8'(m2reg), 8'd1);
    chk("lw_wb_wreg", 8'(wreg), 8'd1);
    chk("lw_wb_regrt", 8'(regrt), 8'd1);
    chk("lw_wb_dmem_req", 8'(dmem_req), 8'd0);
    step();
    chk("lw_ret_state", 8'(state), 8'd1);

    // beq taken
    set_instr(6'b000100, 6'b000000);
    z = 1'b1;
    step();
    chk("beq1_id_state", 8'(state), 8'd2);
    step();
    chk("beq1_exe_state", 8'(state), 8'd3);
    chk("beq1_exe_wpc", 8'(wpc), 8'd1);
    chk("beq1_exe_pcsrc", 8'(pcsource), 8'd1);
    chk("beq1_exe_aluc", 8'(aluc), 8'h4);
    step();
    chk("beq1_ret_state", 8'(state), 8'd1);
    // beq not taken
    z = 1'b0;
    step();
    step();
    chk("beq0_exe_state", 8'(state), 8'd3);
    chk("beq0_exe_wpc", 8'(wpc), 8'd0);
    step();
    chk("beq0_ret_state", 8'(state), 8'd1);

    // bne with z=0 is taken
    set_instr(6'b000101, 6'b000000);
    step();
    step();
    chk("bne_exe_wpc", 8'(wpc), 8'd1);
    chk("bne_exe_pcsrc", 8'(pcsource), 8'd1);
    step();

    // jal resolves in ID
    set_instr(6'b000011, 6'b000000);
    step();
    chk("jal_id_state", 8'(state), 8'd2);
    chk("jal_id_wpc", 8'(wpc), 8'd1);
    chk("jal_id_pcsrc", 8'(pcsource), 8'd3);
    chk("jal_id_wreg", 8'(wreg), 8'd1);
    chk("jal_id_jal", 8'(jal), 8'd1);
    step();
    chk("jal_ret_state", 8'(state), 8'd1);

    // jr resolves in ID
    set_instr(6'b000000, 6'b001000);
    step();
    chk("jr_id_wpc", 8'(wpc), 8'd1);
    chk("jr_id_pcsrc", 8'(pcsource), 8'd2);
    chk("jr_id_wreg", 8'(wreg), 8'd0);
    step();
    chk("jr_ret_state", 8'(state), 8'd1);

    // sra: shift decode and aluc
    set_instr(6'b000000, 6'b000011);
    step();
    step();
    chk("sra_exe_aluc", 8'(aluc), 8'hf);
    chk("sra_exe_shift", 8'(shift), 8'd1);
    step();
    chk("sra_wb_state", 8'(state), 8'd5);
    step();

    // lui
    set_instr(6'b001111, 6'b000000);
    step();
    step();
    chk("lui_exe_aluc", 8'(aluc), 8'h6);
    chk("lui_exe_regrt", 8'(regrt), 8'd1);
    chk("lui_exe_sext", 8'(sext), 8'd0);
    step();
    step();

    // illegal opcode
    set_instr(6'b111111, 6'b000000);
    step();
    chk("ill_id_state", 8'(state), 8'd2);
    chk("ill_id_illegal", 8'(illegal), 8'd1);
    chk("ill_id_wreg", 8'(wreg), 8'd0);
    chk("ill_id_wpc", 8'(wpc), 8'd0);
    chk("ill_id_dmem_req", 8'(dmem_req), 8'd0);
    step();
    chk("ill_ret_state", 8'(state), 8'd1);
    chk("ill_ret_illegal", 8'(illegal), 8'd0);

    // sw completing normally
    set_instr(6'b101011, 6'b000000);
    step();
    step();
    step();
    chk("sw_mem_state", 8'(state), 8'd4);
    chk("sw_mem_we", 8'(dmem_we), 8'd1);
    step();
    chk("sw_ret_state", 8'(state), 8'd1);

    // sw with reset mid-MEM
    step();
    step();
    dmem_ready = 1'b0;
    step();
    chk("swr_mem_state", 8'(state), 8'd4);
    chk("swr_mem_req", 8'(dmem_req), 8'd1);
    #2 reset = 1'b1;
    #1 chk("swr_rst_state", 8'(state), 8'd0);
    chk("swr_rst_dmem_req", 8'(dmem_req), 8'd0);
    chk("swr_rst_dmem_we", 8'(dmem_we), 8'd0);
    step();
    chk("swr_hold_state", 8'(state), 8'd0);
    reset = 1'b0;
    dmem_ready = 1'b1;
    #1 chk("swr_rel_imem_req", 8'(imem_req), 8'd0);
    step();
    chk("swr_resume_state", 8'(state), 8'd1);
    chk("swr_resume_imem_req", 8'(imem_req), 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
